io_uart: RTL

Memory-mapped UART responder on the CPU's IO port bus: it decodes IO accesses addressed to its base port and serialises written bytes onto a TX line through a small FIFO. It sits beside RAM and the BIOS ROM as the far end of CPU IO accesses, i.e. those where the upper address half is all ones and the address is outside the BIOS window. An optional RX path deserialises incoming bytes for the CPU to read back.

---
 rtl/io_pkg.sv | 23 ++
 rtl/uart_fifo.sv | 53 +++++
 rtl/io_uart.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared IO-space constants for io_uart: register offsets, STATUS bit indices
// and the UART frame state enum used by both the TX and RX engines.
package io_pkg;

    localparam logic [7:0] IO_UART_TXDATA = 8'h00;
    localparam logic [7:0] IO_UART_STATUS = 8'h04;
    localparam logic [7:0] IO_UART_RXDATA = 8'h08;

    localparam int unsigned ST_TX_FULL  = 8;
    localparam int unsigned ST_TX_EMPTY = 9;
    localparam int unsigned ST_TX_BUSY  = 10;
    localparam int unsigned ST_OVF      = 11;
    localparam int unsigned ST_RX_VALID = 12;
    localparam int unsigned ST_RX_OVR   = 13;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/io_uart.sv
// IO-port UART responder: byte writes to TXDATA are queued and sent as 8N1.
// Optional RX path is compiled in with the IO_UART_RX_EN macro.
module io_uart
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_PORT    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] port,
    input  logic        isIO,
    input  logic [1:0]  pulse,
    input  logic        rw,
    input  logic [3:0]  size,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        rdata_valid,
    output logic        tx,
    input  logic        rx
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic        sel, wr_txdata, clr_sticky, rd_rxdata, rd_any;
    logic [7:0]  offset;
    logic        tx_pop, tx_full, tx_empty;
    logic [CW-1:0] tx_count;
    logic [7:0]  tx_fifo_data;
    logic        rx_valid_w, rx_ovr_w;
    logic [7:0]  rx_data_w;
    logic [63:0] status_w, rd_mux;
    logic        unused_bus;

    uart_state_e tx_state_q;
    logic [15:0] tx_baud_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_q, ovf_q, rdata_valid_q;
    logic [63:0] rdata_q;

    assign sel        = isIO & pulse[0] & (port[31:8] == BASE_PORT[31:8]);
    assign offset     = port[7:0];
    assign wr_txdata  = sel & rw & (offset == IO_UART_TXDATA);
    assign clr_sticky = sel & rw & (offset == IO_UART_STATUS) & wdata[0];
    assign rd_rxdata  = sel & ~rw & (offset == IO_UART_RXDATA);
    assign rd_any     = sel & ~rw;
    assign unused_bus = ^{size, pulse[1], wdata[63:8]};

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .wdata (wdata[7:0]),
        .pop   (tx_pop),
        .rdata (tx_fifo_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Pop in IDLE or on the last STOP cycle, so back-to-back frames have no gap.
    assign tx_pop = ~tx_empty & ((tx_state_q == UART_IDLE) |
                                 ((tx_state_q == UART_STOP) & (tx_baud_q == '0)));

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= UART_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                UART_IDLE: begin
                    if (tx_pop) begin
                        tx_shift_q <= tx_fifo_data;
                        tx_baud_q  <= BAUD_LAST;
                        tx_q       <= 1'b0;
                        tx_state_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (tx_baud_q == '0) begin
                        tx_baud_q  <= BAUD_LAST;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_state_q <= UART_DATA;
                    end else begin
                        tx_baud_q <= tx_baud_q - 1'b1;
                    end
                end
                UART_DATA: begin
                    if (tx_baud_q == '0) begin
                        tx_baud_q <= BAUD_LAST;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= UART_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q - 1'b1;
                    end
                end
                UART_STOP: begin
                    if (tx_baud_q == '0) begin
                        if (tx_pop) begin
                            tx_shift_q <= tx_fifo_data;
                            tx_baud_q  <= BAUD_LAST;
                            tx_q       <= 1'b0;
                            tx_state_q <= UART_START;
                        end else begin
                            tx_state_q <= UART_IDLE;
                        end
                    end else begin
                        tx_baud_q <= tx_baud_q - 1'b1;
                    end
                end
                default: tx_state_q <= UART_IDLE;
            endcase
        end
    end

`ifdef IO_UART_RX_EN
    localparam logic [15:0] BAUD_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]  rx_sync_q;
    uart_state_e rx_state_q;
    logic [15:0] rx_baud_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_data_q;
    logic        rx_valid_q, rx_ovr_q, rx_s;

    assign rx_s       = rx_sync_q[1];
    assign rx_valid_w = rx_valid_q;
    assign rx_ovr_w   = rx_ovr_q;
    assign rx_data_w  = rx_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= UART_IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx};
            if (rd_rxdata) rx_valid_q <= 1'b0;
            if (clr_sticky) rx_ovr_q <= 1'b0;
            case (rx_state_q)
                UART_IDLE: begin
                    if (!rx_s) begin
                        rx_baud_q  <= BAUD_HALF;
                        rx_state_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (rx_baud_q == '0) begin
                        rx_baud_q  <= BAUD_LAST;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s ? UART_IDLE : UART_DATA;
                    end else begin
                        rx_baud_q <= rx_baud_q - 1'b1;
                    end
                end
                UART_DATA: begin
                    if (rx_baud_q == '0) begin
                        rx_baud_q  <= BAUD_LAST;
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) rx_state_q <= UART_STOP;
                    end else begin
                        rx_baud_q <= rx_baud_q - 1'b1;
                    end
                end
                UART_STOP: begin
                    if (rx_baud_q == '0) begin
                        rx_state_q <= UART_IDLE;
                        if (rx_s) begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !rd_rxdata) rx_ovr_q <= 1'b1;
                        end
                    end else begin
                        rx_baud_q <= rx_baud_q - 1'b1;
                    end
                end
                default: rx_state_q <= UART_IDLE;
            endcase
        end
    end
`else
    logic unused_rx;
    assign unused_rx  = rx;
    assign rx_valid_w = 1'b0;
    assign rx_ovr_w   = 1'b0;
    assign rx_data_w  = '0;
`endif

    always_comb begin
        status_w              = '0;
        status_w[7:0]         = 8'(tx_count);
        status_w[ST_TX_FULL]  = tx_full;
        status_w[ST_TX_EMPTY] = tx_empty;
        status_w[ST_TX_BUSY]  = (tx_state_q != UART_IDLE);
        status_w[ST_OVF]      = ovf_q;
        status_w[ST_RX_VALID] = rx_valid_w;
        status_w[ST_RX_OVR]   = rx_ovr_w;
    end

    always_comb begin
        rd_mux = '0;
        case (offset)
            IO_UART_STATUS: rd_mux = status_w;
            IO_UART_RXDATA: rd_mux = rx_valid_w ? {56'b0, rx_data_w} : '0;
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            if (clr_sticky) begin
                ovf_q <= 1'b0;
            end else if (wr_txdata && tx_full && !tx_pop) begin
                ovf_q <= 1'b1;
            end
            rdata_valid_q <= rd_any;
            if (rd_any) rdata_q <= rd_mux;
        end
    end

    assign tx          = tx_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule
